// File: rtl/input_keypad_scan_pkg.sv
// Shared constants for the 4x4 keypad scanner: matrix geometry, key index
// mapping and the column drive pattern loaded at reset.
package input_keypad_scan_pkg;

  localparam int unsigned KP_ROWS    = 4;
  localparam int unsigned KP_COLS    = 4;
  localparam int unsigned KEY_STRIDE = 4;
  localparam int unsigned KEY_W      = KP_ROWS * KP_COLS;
  localparam int unsigned KEY_IDX_W  = $clog2(KEY_W);
  localparam int unsigned COL_IDX_W  = $clog2(KP_COLS);
  localparam int unsigned ROW_IDX_W  = $clog2(KP_ROWS);

  // Column 0 driven low out of reset.
  localparam logic [KP_COLS-1:0] COL_RESET = 4'b1110;

  // Key index for a (column, row) position: col*stride + row.
  function automatic logic [KEY_IDX_W-1:0] key_idx(input logic [COL_IDX_W-1:0] c,
                                                   input logic [ROW_IDX_W-1:0] r);
    return KEY_IDX_W'(32'(c) * KEY_STRIDE + 32'(r));
  endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// Frame-rate debouncer for a single key.
//   clk, rst_n : clock, async active-low reset
//   en         : frame strobe; state only advances when high
//   raw        : sampled key level for the frame just completed
//   stable     : debounced level, flips after DEB_N consecutive disagreeing frames
module input_debounce_bit #(
  parameter int unsigned DEB_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEB_N + 1);

  logic [CNT_W-1:0] cnt;

  // Count disagreeing frames; any agreeing frame restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (en) begin
      if (raw == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEB_N - 1)) begin
        stable <= raw;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/input_keypad_scan.sv
// 4x4 membrane keypad scanner: column drive, row synchronisation, raw frame
// capture and per-key debounce.
//   clk, rst_n : clock, async active-low reset
//   row        : active-low row lines, asynchronous to clk
//   col        : active-low column drive, one bit low at a time
//   key        : debounced pressed-key vector, index = col*4 + row
//   frame      : one-cycle pulse in the cycle key may update
module input_keypad_scan
  import input_keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEB_N    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KP_ROWS-1:0] row,
  output logic [KP_COLS-1:0] col,
  output logic [KEY_W-1:0]   key,
  output logic               frame
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]     div_q;
  logic [COL_IDX_W-1:0] col_idx;
  logic [KP_ROWS-1:0]   row_m;
  logic [KP_ROWS-1:0]   row_s;
  logic [KEY_W-1:0]     raw;
  logic [KEY_W-1:0]     raw_nxt_c;
  logic                 sample_c;
  logic                 last_col_c;

  assign sample_c   = (div_q == DIV_W'(SCAN_DIV - 1));
  assign last_col_c = (col_idx == COL_IDX_W'(KP_COLS - 1));

  // Merge the synchronised rows of the current column into the raw frame.
  always_comb begin
    raw_nxt_c = raw;
    for (int unsigned r = 0; r < KP_ROWS; r++) begin
      raw_nxt_c[key_idx(col_idx, ROW_IDX_W'(r))] = ~row_s[r];
    end
  end

  // Synchroniser, divider, column rotator, raw capture and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m   <= '1;
      row_s   <= '1;
      div_q   <= '0;
      col_idx <= '0;
      col     <= COL_RESET;
      raw     <= '0;
      frame   <= 1'b0;
    end else begin
      row_m <= row;
      row_s <= row_m;
      frame <= sample_c && last_col_c;
      if (sample_c) begin
        raw     <= raw_nxt_c;
        div_q   <= '0;
        col_idx <= col_idx + COL_IDX_W'(1);
        col     <= {col[KP_COLS-2:0], col[KP_COLS-1]};
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // One debouncer per key, all advanced by the frame strobe.
  for (genvar i = 0; i < KEY_W; i++) begin : g_deb
    input_debounce_bit #(
      .DEB_N (DEB_N)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (frame),
      .raw    (raw[i]),
      .stable (key[i])
    );
  end

endmodule

// File: tb/tb_input_keypad_scan.sv
// Testbench for input_keypad_scan with SCAN_DIV=4, DEB_N=3 (16-cycle frames).
module tb_input_keypad_scan;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [15:0] key;
  logic        frame;

  logic [15:0] pressed;
  logic [15:0] prev_exp;
  logic [15:0] exp_q[$];
  int          checks;
  int          errors;

  typedef struct {
    logic [15:0] mask;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[32];

  input_keypad_scan #(
    .SCAN_DIV (4),
    .DEB_N    (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .row   (row),
    .col   (col),
    .key   (key),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a pressed key pulls its row low while its column is driven.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (pressed[c*4+r] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Column stepping and frame quiet for n cycles after a reset release.
  task automatic check_scan(input int n);
    logic [3:0] one;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      one = 4'b0001 << ((k / 4) % 4);
      chk("col_step", {12'h0, col}, {12'h0, ~one});
      chk("frame_quiet", {15'h0, frame}, 16'h0);
    end
  endtask

  // Apply table rows lo..hi, one per frame; the mask for row lo must already be on.
  task automatic run_vec(input int lo, input int hi);
    logic [15:0] got;
    bit seen;
    for (int i = lo; i <= hi; i++) begin
      exp_q.push_back(tbl[i].exp);
      seen = 1'b0;
      for (int n = 0; n < 64; n++) begin
        @(negedge clk);
        chk("key_hold", key, prev_exp);
        if (frame) begin
          seen = 1'b1;
          break;
        end
      end
      if (!seen) begin
        checks++;
        errors++;
        $display("FAIL frame_timeout vec %0d: got no frame expected pulse", i);
      end
      if (i < hi) pressed = tbl[i+1].mask;
      @(negedge clk);
      got = exp_q.pop_front();
      chk($sformatf("key_vec%0d", i), key, got);
      chk("frame_width", {15'h0, frame}, 16'h0);
      prev_exp = got;
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    prev_exp = 16'h0;
    pressed  = 16'h0;

    tbl[0]  = '{16'h0000, 16'h0000};
    tbl[1]  = '{16'h0200, 16'h0000};
    tbl[2]  = '{16'h0200, 16'h0000};
    tbl[3]  = '{16'h0200, 16'h0200};
    tbl[4]  = '{16'h0200, 16'h0200};
    tbl[5]  = '{16'h0000, 16'h0200};
    tbl[6]  = '{16'h0000, 16'h0200};
    tbl[7]  = '{16'h0000, 16'h0000};
    tbl[8]  = '{16'h0200, 16'h0000};
    tbl[9]  = '{16'h0200, 16'h0000};
    tbl[10] = '{16'h0000, 16'h0000};
    tbl[11] = '{16'h0200, 16'h0000};
    tbl[12] = '{16'h0200, 16'h0000};
    tbl[13] = '{16'h0000, 16'h0000};
    tbl[14] = '{16'h0000, 16'h0000};
    tbl[15] = '{16'h8001, 16'h0000};
    tbl[16] = '{16'h8001, 16'h0000};
    tbl[17] = '{16'h8001, 16'h8001};
    tbl[18] = '{16'h8001, 16'h8001};
    tbl[19] = '{16'h0000, 16'h8001};
    tbl[20] = '{16'h0000, 16'h8001};
    tbl[21] = '{16'h0000, 16'h0000};
    tbl[22] = '{16'h0421, 16'h0000};
    tbl[23] = '{16'h0421, 16'h0000};
    tbl[24] = '{16'h0420, 16'h0420};
    tbl[25] = '{16'h0420, 16'h0420};
    tbl[26] = '{16'h8001, 16'h0420};
    tbl[27] = '{16'h8001, 16'h0420};
    tbl[28] = '{16'h8001, 16'h8001};
    tbl[29] = '{16'h8001, 16'h0000};
    tbl[30] = '{16'h8001, 16'h0000};
    tbl[31] = '{16'h8001, 16'h8001};

    // Power-on reset.
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_col", {12'h0, col}, 16'h000E);
    chk("rst_key", key, 16'h0000);
    chk("rst_frame", {15'h0, frame}, 16'h0);
    repeat (3) @(negedge clk);
    chk("rst_hold_col", {12'h0, col}, 16'h000E);
    pressed = tbl[0].mask;
    rst_n = 1'b1;
    check_scan(15);
    run_vec(0, 28);

    // Reset mid-frame with 0 and 15 held.
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_key", key, 16'h0000);
    chk("mid_rst_col", {12'h0, col}, 16'h000E);
    chk("mid_rst_frame", {15'h0, frame}, 16'h0);
    repeat (2) @(negedge clk);
    prev_exp = 16'h0;
    rst_n = 1'b1;
    check_scan(15);
    run_vec(29, 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_keypad_scan.md
Name: input_keypad_scan

Overview:
- Upstream of the command encoder. Drives a 4x4 membrane keypad matrix by column and samples its rows.
- Synchronises and debounces the row inputs, then presents a stable 16-bit pressed-key level vector `key[15:0]`.
- The encoder edge-detects and prioritises this vector into commands.
- One clock domain; the row pins are asynchronous to it.

Parameters:
- SCAN_DIV, 1000, clock cycles each column is driven; legal range >= 4.
- DEB_N, 4, consecutive full-matrix frames a key must disagree with its current output before the output flips; legal range 1..15.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset; asserts immediately, releases on any edge.
- row  in  4  keypad row lines; active-low (pulled up); asynchronous.
- col  out  4  column drive; active-low, exactly one bit low at all times.
- key  out  16  debounced key state; 1 = pressed. Index = col_idx*4 + row_idx.
- frame  out  1  one-cycle pulse in the cycle key may update, i.e. after column 3 is sampled.

Behaviour:
- Reset values (async, Reset=0):
  - col=4'b1110, key=16'h0000, frame=0.
  - Column index=0, divider=0.
  - Synchroniser flops=4'b1111, raw frame=16'h0000, all debounce counters=0.
- Synchroniser: row passes through 2 flops (row_s). No logic reads row before the second flop.
- Divider counts 0..SCAN_DIV-1 per column.
- On divider==SCAN_DIV-1 (the sample cycle):
  - raw[col_idx*4 + r] <= ~row_s[r] for r=0..3.
  - col_idx advances 0->1->2->3->0.
  - col rotates left; the driven-low bit equals the new col_idx.
  - divider wraps to 0.
  - The sample taken reflects a column driven for at least SCAN_DIV-3 settled cycles.
- Frame completion: the sample cycle of col_idx==3 completes a frame.
  - Debounce evaluation happens the following cycle, with frame=1 in that cycle.
  - Frame period = 4*SCAN_DIV cycles.
- Debounce, per key i, at each frame evaluation:
  - If raw[i]==key[i]: cnt[i] <= 0.
  - Else if cnt[i]==DEB_N-1: key[i] <= raw[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any agreeing frame restarts the count. There is no decay.
- Latency: a clean press present from the start of a frame sets key[i] at the frame pulse of the DEB_N-th frame containing it. Release is symmetric.
- Simultaneous keys: each key is debounced independently, with no priority. Ghost keys from 3-key rectangles are reported as sampled; there is no anti-ghosting.
- Wrap-around: column index and divider wrap silently. cnt[i] never exceeds DEB_N-1.
- Reset mid-frame: all state clears at once. Scanning restarts at column 0 on the first edge after release. Partially debounced presses are discarded.
- key changes only in frame cycles. Between frames it holds, so the downstream edge detector sees at most one transition per key per frame.

Decomposition:
- Shared include: KP_ROWS=4, KP_COLS=4, the key-index mapping constant (stride 4), and the reset column pattern 4'b1110.
- Sub-module input_debounce_bit, 16 instances.
  - Inputs: Clock, Reset, en (the frame strobe), raw.
  - Output: the stable level.
  - Contains the saturating counter of width clog2(DEB_N+1).
- Parent holds the divider, column rotator, synchroniser and raw register.

Test Plan (SCAN_DIV=4, DEB_N=3, frame=16 cycles):
- Reset low with rows all 1 -> col=1110, key=0000, frame=0. After release: col steps 1110->1101->1011->0111->1110 every 4 cycles; frame pulses every 16 cycles.
- Hold key (col2,row1) by driving row[1]=0 whenever col[2]=0 -> key=16'h0200 at the 3rd frame pulse after the first complete frame containing the press; key=0 before that.
- Bounce: press for 2 frames, release 1 frame, press 2 frames, release -> key stays 16'h0000 throughout.
- Release a stable 16'h0200 -> clears to 0000 at the 3rd frame pulse after release; no intermediate glitch.
- Press keys 0 (col0,row0) and 15 (col3,row3) together -> key=16'h8001, both bits setting in the same frame cycle.
- Assert Reset mid-frame while key=16'h8001 -> key=0 and col=1110 asynchronously within the cycle. After release with keys still held, key=16'h8001 again after 3 full frames.
